// File: rtl/alu_bus_pkg.sv
// Shared opcodes, register offsets and FSM states for the integer-ALU bus master.
package alu_bus_pkg;

  localparam logic [3:0] ADD      = 4'h0;
  localparam logic [3:0] SUBTRACT = 4'h1;
  localparam logic [3:0] MULTIPLY = 4'h2;
  localparam logic [3:0] DIVIDE   = 4'h3;

  localparam logic [3:0] SRC1 = 4'h0;
  localparam logic [3:0] SRC2 = 4'h1;
  localparam logic [3:0] RES  = 4'h2;
  localparam logic [3:0] EXEC = 4'h3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_A,
    ST_WR_B,
    ST_EXEC,
    ST_RD,
    ST_CAP,
    ST_ERR
  } state_t;

endpackage

// File: rtl/int_alu_bus_master.sv
// Runs write-src1 / write-src2 / trigger / read on the integer-ALU bus for one request.
// 6 cycles per op (done in cycle 6); rejected requests finish in 2; start ignored unless ready.
module int_alu_bus_master
  import alu_bus_pkg::*;
#(
  parameter logic [3:0] UNIT_SEL = 4'h3,
  parameter int         DATA_W   = 256,
  parameter int         OPND_W   = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [3:0]        op,
  input  logic [OPND_W-1:0] opnd_a,
  input  logic [OPND_W-1:0] opnd_b,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] result,
  output logic [15:0]       address,
  output logic              nRead,
  output logic              nWrite,
  output logic [DATA_W-1:0] ExeDataOut,
  input  logic [DATA_W-1:0] IntDataOut
);

  state_t             state_q, state_d;
  logic [3:0]         op_q, op_d;
  logic [OPND_W-1:0]  a_q, a_d;
  logic [OPND_W-1:0]  b_q, b_d;
  logic [DATA_W-1:0]  result_q, result_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d = op;
          a_d  = opnd_a;
          b_d  = opnd_b;
          // Unknown opcodes and divide-by-zero never touch the bus.
          if (op > DIVIDE || (op == DIVIDE && opnd_b == '0)) state_d = ST_ERR;
          else                                               state_d = ST_WR_A;
        end
      end
      ST_WR_A: state_d = ST_WR_B;
      ST_WR_B: state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RD;
      ST_RD:   state_d = ST_CAP;
      ST_CAP: begin
        result_d = IntDataOut;
        done_d   = 1'b1;
        state_d  = ST_IDLE;
      end
      ST_ERR: begin
        result_d = '0;
        done_d   = 1'b1;
        err_d    = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    address    = 16'h0000;
    nRead      = 1'b1;
    nWrite     = 1'b1;
    ExeDataOut = '0;
    case (state_q)
      ST_WR_A: begin
        address    = {UNIT_SEL, 8'h00, SRC1};
        nWrite     = 1'b0;
        ExeDataOut = DATA_W'(a_q);
      end
      ST_WR_B: begin
        address    = {UNIT_SEL, 8'h00, SRC2};
        nWrite     = 1'b0;
        ExeDataOut = DATA_W'(b_q);
      end
      ST_EXEC: address = {UNIT_SEL, 4'h0, op_q, EXEC};
      ST_RD: begin
        address = {UNIT_SEL, 8'h00, RES};
        nRead   = 1'b0;
      end
      default: ;
    endcase
  end

  assign ready  = (state_q == ST_IDLE);
  assign busy   = (state_q != ST_IDLE);
  assign done   = done_q;
  assign err    = err_q;
  assign result = result_q;

endmodule

// File: tb/tb_int_alu_bus_master.sv
// Bench for int_alu_bus_master: behavioural IntegerALU on the bus plus a spec-level result model.
module tb_int_alu_bus_master;

  logic         Clk = 1'b0;
  logic         Reset = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   op = 4'h0;
  logic [15:0]  opnd_a = 16'h0;
  logic [15:0]  opnd_b = 16'h0;
  logic         ready, busy, done, err;
  logic [255:0] result;
  logic [15:0]  address;
  logic         nRead, nWrite;
  logic [255:0] ExeDataOut;
  logic [255:0] IntDataOut = '0;

  int_alu_bus_master dut (
    .Clk(Clk), .Reset(Reset), .start(start), .op(op), .opnd_a(opnd_a), .opnd_b(opnd_b),
    .ready(ready), .busy(busy), .done(done), .err(err), .result(result),
    .address(address), .nRead(nRead), .nWrite(nWrite), .ExeDataOut(ExeDataOut),
    .IntDataOut(IntDataOut)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc_cnt = 0;
  always @(posedge Clk) cyc_cnt++;

  // IntegerALU: snapshot the bus mid-cycle, act on it at the edge ending that cycle.
  logic [15:0]  bus_addr = '0;
  logic         bus_nr = 1'b1, bus_nw = 1'b1;
  logic [255:0] bus_dat = '0;
  logic [255:0] s1 = '0, s2 = '0, acc = '0;
  always @(negedge Clk) begin
    bus_addr = address; bus_nr = nRead; bus_nw = nWrite; bus_dat = ExeDataOut;
  end
  always @(posedge Clk) begin
    if (!bus_nw && bus_addr == 16'h3000) s1 = bus_dat;
    if (!bus_nw && bus_addr == 16'h3001) s2 = bus_dat;
    if (bus_nr && bus_nw && bus_addr[15:8] == 8'h30 && bus_addr[3:0] == 4'h3)
      case (bus_addr[7:4])
        4'h0: acc = s1 + s2;
        4'h1: acc = s1 - s2;
        4'h2: acc = s1 * s2;
        4'h3: acc = (s2 != 0) ? s1 / s2 : '0;
        default: acc = '0;
      endcase
    if (!bus_nr && bus_addr == 16'h3002) IntDataOut <= acc;
  end

  function automatic logic [255:0] ref_res(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b);
    logic [255:0] x, y;
    x = 256'(a); y = 256'(b);
    case (o)
      4'h0: return x + y;
      4'h1: return x - y;
      4'h2: return x * y;
      4'h3: return (b == 0) ? '0 : x / y;
      default: return '0;
    endcase
  endfunction

  function automatic bit ref_err(input logic [3:0] o, input logic [15:0] b);
    return (o > 4'h3) || (o == 4'h3 && b == 16'h0);
  endfunction

  // Observations of one request, filled by do_op.
  logic [15:0]  tr_addr[$];
  logic [15:0]  tr_dat[$];
  int           done_cyc, done_abs, wait_cyc;
  logic [255:0] obs_res;
  logic         obs_err, clash, stray, busy_c1, ready_c1;

  // Call at a negedge; returns at the negedge of the done cycle (or after the budget).
  task automatic do_op(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b);
    tr_addr.delete(); tr_dat.delete();
    done_cyc = -1; obs_res = 'x; obs_err = 1'bx; clash = 0; stray = 0; wait_cyc = 0;
    while (!ready && wait_cyc < 20) begin @(negedge Clk); wait_cyc++; end
    start = 1'b1; op = o; opnd_a = a; opnd_b = b;
    @(negedge Clk);
    start = 1'b0; op = 4'($urandom); opnd_a = 16'($urandom); opnd_b = 16'($urandom);
    for (int c = 1; c <= 20; c++) begin
      if (!nRead && !nWrite) clash = 1;
      if (nWrite && ExeDataOut != 0) stray = 1;
      if (address != 16'h0 || !nRead || !nWrite) tr_addr.push_back(address);
      if (!nWrite) tr_dat.push_back(ExeDataOut[15:0]);
      if (c == 1) begin busy_c1 = busy; ready_c1 = ready; end
      if (done) begin
        done_cyc = c; obs_res = result; obs_err = err; done_abs = cyc_cnt;
        break;
      end
      @(negedge Clk);
    end
  endtask

  task automatic test_reset;
    #1 Reset = 1'b1;
    #1;
    n_cmp++; if (address !== 16'h0) begin n_err++; $display("FAIL rst_address: got %h want 0000", address); end
    n_cmp++; if (nRead !== 1'b1 || nWrite !== 1'b1) begin n_err++; $display("FAIL rst_strobes: got %b%b want 11", nRead, nWrite); end
    n_cmp++; if (ExeDataOut !== '0) begin n_err++; $display("FAIL rst_exedata: got %h want 0", ExeDataOut); end
    n_cmp++; if (result !== '0) begin n_err++; $display("FAIL rst_result: got %h want 0", result); end
    n_cmp++; if ({done, err, busy, ready} !== 4'b0001) begin n_err++; $display("FAIL rst_ctrl: got done/err/busy/ready=%b want 0001", {done, err, busy, ready}); end
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    n_cmp++; if (ready !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL rst_release: got ready=%b busy=%b want 1/0", ready, busy); end
  endtask

  task automatic test_multiply;
    logic [15:0] exp_a [4];
    exp_a = '{16'h3000, 16'h3001, 16'h3023, 16'h3002};
    do_op(4'h2, 16'd7, 16'd6);
    n_cmp++; if (tr_addr.size() != 4) begin n_err++; $display("FAIL mul_trace_len: got %0d want 4", tr_addr.size()); end
    else for (int i = 0; i < 4; i++) begin
      n_cmp++; if (tr_addr[i] !== exp_a[i]) begin n_err++; $display("FAIL mul_addr%0d: got %h want %h", i, tr_addr[i], exp_a[i]); end
    end
    n_cmp++; if (tr_dat.size() != 2 || tr_dat[0] !== 16'd7 || tr_dat[1] !== 16'd6) begin n_err++; $display("FAIL mul_wdata: got %0d words, want 7 then 6", tr_dat.size()); end
    n_cmp++; if (done_cyc != 6) begin n_err++; $display("FAIL mul_done_cycle: got %0d want 6", done_cyc); end
    n_cmp++; if (obs_res !== 256'h2A || obs_err !== 1'b0) begin n_err++; $display("FAIL mul_result: got %h err=%b want 2a err=0", obs_res, obs_err); end
    n_cmp++; if (busy_c1 !== 1'b1 || ready_c1 !== 1'b0) begin n_err++; $display("FAIL mul_busy: got busy=%b ready=%b want 1/0", busy_c1, ready_c1); end
    n_cmp++; if (clash || stray) begin n_err++; $display("FAIL mul_bus_rules: got clash=%b stray=%b want 0/0", clash, stray); end
  endtask

  task automatic test_back_to_back;
    int first_done;
    do_op(4'h1, 16'd5, 16'd9);
    first_done = done_abs;
    n_cmp++; if (obs_res !== ref_res(4'h1, 16'd5, 16'd9)) begin n_err++; $display("FAIL sub_wrap: got %h want %h", obs_res, ref_res(4'h1, 16'd5, 16'd9)); end
    do_op(4'h0, 16'hFFFF, 16'h0001);
    n_cmp++; if (wait_cyc != 0) begin n_err++; $display("FAIL b2b_accept: got %0d wait cycles want 0", wait_cyc); end
    n_cmp++; if (done_abs - first_done != 6) begin n_err++; $display("FAIL b2b_spacing: got %0d want 6", done_abs - first_done); end
    n_cmp++; if (obs_res !== 256'h10000 || obs_err !== 1'b0) begin n_err++; $display("FAIL add_carry: got %h err=%b want 10000 err=0", obs_res, obs_err); end
  endtask

  task automatic test_divide;
    do_op(4'h3, 16'd100, 16'd7);
    n_cmp++; if (obs_res !== 256'd14 || obs_err !== 1'b0) begin n_err++; $display("FAIL div_result: got %h err=%b want e err=0", obs_res, obs_err); end
    do_op(4'h3, 16'd5, 16'd0);
    n_cmp++; if (tr_addr.size() != 0) begin n_err++; $display("FAIL div0_bus: got %0d bus cycles want 0", tr_addr.size()); end
    n_cmp++; if (done_cyc != 2 || obs_err !== 1'b1) begin n_err++; $display("FAIL div0_err: got cycle %0d err=%b want 2 err=1", done_cyc, obs_err); end
    n_cmp++; if (obs_res !== '0) begin n_err++; $display("FAIL div0_result: got %h want 0", obs_res); end
  endtask

  task automatic test_bad_op;
    do_op(4'h5, 16'd3, 16'd4);
    n_cmp++; if (tr_addr.size() != 0 || done_cyc != 2 || obs_err !== 1'b1) begin n_err++; $display("FAIL badop: got bus=%0d cycle=%0d err=%b want 0/2/1", tr_addr.size(), done_cyc, obs_err); end
  endtask

  task automatic test_start_held;
    int ndone, d0, d1;
    ndone = 0; d0 = -1; d1 = -1;
    start = 1'b1; op = 4'h0; opnd_a = 16'd1; opnd_b = 16'd2;
    for (int c = 1; c <= 20; c++) begin
      @(negedge Clk);
      if (done) begin
        if (ndone == 0) d0 = c; else d1 = c;
        ndone++;
      end
      if (c == 12) start = 1'b0;
    end
    n_cmp++; if (ndone != 2 || d0 != 6 || d1 != 12) begin n_err++; $display("FAIL held_start: got %0d dones at %0d,%0d want 2 at 6,12", ndone, d0, d1); end
    n_cmp++; if (result !== 256'd3 || ready !== 1'b1) begin n_err++; $display("FAIL held_result: got %h ready=%b want 3 ready=1", result, ready); end
  endtask

  task automatic test_reset_mid;
    int ndone;
    start = 1'b1; op = 4'h2; opnd_a = 16'd9; opnd_b = 16'd9;
    @(negedge Clk); start = 1'b0;
    @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    n_cmp++; if (address !== 16'h0 || nWrite !== 1'b1 || nRead !== 1'b1 || ExeDataOut !== '0) begin n_err++; $display("FAIL midrst_bus: got addr=%h nR=%b nW=%b want 0000/1/1", address, nRead, nWrite); end
    n_cmp++; if ({done, err, busy, ready} !== 4'b0001) begin n_err++; $display("FAIL midrst_ctrl: got %b want 0001", {done, err, busy, ready}); end
    @(negedge Clk); Reset = 1'b0;
    ndone = 0;
    for (int c = 0; c < 10; c++) begin @(negedge Clk); if (done) ndone++; end
    n_cmp++; if (ndone != 0) begin n_err++; $display("FAIL midrst_nodone: got %0d dones want 0", ndone); end
    do_op(4'h2, 16'd3, 16'd4);
    n_cmp++; if (obs_res !== 256'd12 || done_cyc != 6) begin n_err++; $display("FAIL midrst_after: got %h at cycle %0d want c at 6", obs_res, done_cyc); end
  endtask

  task automatic test_random;
    logic [3:0]  o;
    logic [15:0] a, b;
    bit          e;
    for (int i = 0; i < 24; i++) begin
      o = (i % 6 == 5) ? 4'($urandom_range(15, 4)) : 4'($urandom_range(3, 0));
      a = 16'($urandom);
      b = (i % 7 == 3) ? 16'h0 : 16'($urandom);
      e = ref_err(o, b);
      do_op(o, a, b);
      n_cmp++;
      if (obs_res !== ref_res(o, a, b) || obs_err !== e || done_cyc != (e ? 2 : 6) ||
          tr_addr.size() != (e ? 0 : 4) || clash || stray) begin
        n_err++;
        $display("FAIL rand%0d op=%h a=%h b=%h: got res=%h err=%b cyc=%0d bus=%0d want res=%h err=%b", i, o, a, b,
                 obs_res, obs_err, done_cyc, tr_addr.size(), ref_res(o, a, b), e);
      end else if (!e) begin
        n_cmp++;
        if (tr_addr[2] !== (16'h3003 | (16'(o) << 4))) begin n_err++; $display("FAIL rand%0d_exec_addr: got %h want %h", i, tr_addr[2], 16'h3003 | (16'(o) << 4)); end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_multiply();
    test_back_to_back();
    test_divide();
    test_bad_op();
    @(negedge Clk);
    test_start_held();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/int_alu_bus_master.md
Name: int_alu_bus_master

Overview:
- Initiator side of the integer-ALU register bus.
- Accepts one operation request (opcode plus two 16-bit operands) from the execution engine and runs the bus sequence: write src1, write src2, trigger the operation, read the result.
- Captures the 256-bit result and returns it with a done pulse.
- Sits between the execution-engine control FSM and the IntegerALU bus (address/nRead/nWrite/ExeDataOut/IntDataOut).

Parameters:
- UNIT_SEL, 4'h3, value driven on address[15:12] to select the integer ALU.
- DATA_W, 256, bus data width (ExeDataOut/IntDataOut/result).
- OPND_W, 16, operand width; operands are zero-extended to DATA_W on the bus.

Ports:
- Clk  input  1  clock, all state updates on posedge.
- Reset  input  1  asynchronous, active-high reset.
- start  input  1  request strobe, sampled only when ready=1.
- op  input  4  0=ADD, 1=SUBTRACT, 2=MULTIPLY, 3=DIVIDE.
- opnd_a  input  OPND_W  src1 operand.
- opnd_b  input  OPND_W  src2 operand.
- ready  output  1  high in IDLE only.
- busy  output  1  high from the cycle after acceptance until done.
- done  output  1  one-cycle completion pulse.
- err  output  1  valid with done; 1 = request rejected.
- result  output  DATA_W  captured ALU result, held until the next done.
- address  output  16  ALU bus address.
- nRead  output  1  active-low read strobe.
- nWrite  output  1  active-low write strobe.
- ExeDataOut  output  DATA_W  write data to the ALU.
- IntDataOut  input  DATA_W  read data from the ALU.

Behaviour:
- Reset (asynchronous, immediate, including mid-sequence):
  - state=IDLE, address=16'h0000, nRead=1, nWrite=1, ExeDataOut=0.
  - result=0, done=0, err=0, busy=0, ready=1.
- Bus outputs are a Moore decode of the registered state; they change only on Clk edges or Reset.
- The ALU samples the bus on the edge that ends each state.
- States and bus values:
  - IDLE: address 0000, nRead=1, nWrite=1. If start is sampled, latch op/opnd_a/opnd_b.
    - op>3, or op==DIVIDE with opnd_b==0 -> ERR.
    - Otherwise -> WR_A.
  - WR_A: address {UNIT_SEL,12'h000}, nWrite=0, ExeDataOut={zeros,opnd_a} -> WR_B.
  - WR_B: address {UNIT_SEL,12'h001}, nWrite=0, ExeDataOut={zeros,opnd_b} -> EXEC.
  - EXEC: address {UNIT_SEL,4'h0,op,4'h3}, nRead=1, nWrite=1 -> RD.
  - RD: address {UNIT_SEL,12'h002}, nRead=0, nWrite=1 -> CAP.
  - CAP: address 0000, strobes high. On the ending edge: result<=IntDataOut, done<=1, err<=0 -> IDLE.
  - ERR: no bus activity. On the ending edge: done<=1, err<=1, result<=0 -> IDLE.
- nRead and nWrite are never low together. ExeDataOut returns to 0 outside the WR states.
- Latency (start sampled at edge E0):
  - Normal: WR_A..CAP occupy cycles 1-5; done is high in cycle 6. Next start is accepted at the end of cycle 6, giving 6 cycles/op.
  - Error: done and err are high in cycle 2.
- busy=1 in WR_A..CAP and ERR; ready=(state==IDLE).
- start while not ready is ignored (not queued). Inputs may change after acceptance without effect.
- The ALU computes at full DATA_W:
  - SUBTRACT underflow wraps modulo 2^256.
  - MULTIPLY of 16-bit operands fits in 32 bits.
  - result is passed unmodified.

Decomposition:
- Package alu_bus_pkg holds:
  - Opcode constants ADD/SUBTRACT/MULTIPLY/DIVIDE.
  - Offset constants SRC1=4'h0, SRC2=4'h1, RES=4'h2, EXEC=4'h3.
  - State enum {IDLE, WR_A, WR_B, EXEC, RD, CAP, ERR}.
- Single module, no sub-module; FSM plus output decode fit comfortably in one file.

Test Plan:
- MULTIPLY 7x6 against an IntegerALU instance:
  - Addresses seen are 3000 (data 7), 3001 (data 6), 3023, 3002.
  - done in cycle 6, result=0x2A, err=0.
- SUBTRACT 5-9: result=256'hFFFF...FFFC; then ADD 0xFFFF+1 back-to-back gives result=0x10000; the second start is accepted in the done cycle.
- DIVIDE 100/7: result=14. DIVIDE 5/0: no address other than 0000 driven, done+err in cycle 2, result=0.
- op=4'h5: err=1 with no bus activity. start held high during a busy sequence: exactly one done per accepted request.
- Reset asserted mid-sequence:
  - During WR_B: outputs return to reset values immediately (asynchronous) and no done is produced.
  - After release, MULTIPLY 3x4 returns 12.
